gauss_frame_ctrl: RTL and testbench

- Frame sequencer for the 3x3 line-buffer filter path (Gaussian/Sobel-style window filters with `data_in_en` gating and a `data_out_en` qualifier).
- Sits between the pixel source and the filter:
  - latches the frame size;
  - gates the source into the filter's enable;
  - injects flush enables so the last rows leave the pipeline;
  - re-frames filter output with sof/eol/eof and a done pulse.

---
 rtl/gauss_ctrl_pkg.sv | 31 +++
 rtl/frame_out_framer.sv | 113 +++++++++++
 rtl/gauss_frame_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_gauss_frame_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gauss_ctrl_pkg
// Shared definitions for the 3x3 window-filter frame sequencers.
//   - ctrl_state_e : sequencer states (IDLE, SYNC, FILL, FLUSH, DRAIN)
//   - *_DEF        : default widths and latencies
//   - MIN_DIM      : smallest legal frame width/height (a 3x3 window needs 3)
//   - dims_legal   : frame size legality check
// -----------------------------------------------------------------------------
package gauss_ctrl_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int W_BITS_DEF    = 11;
  localparam int H_BITS_DEF    = 11;
  localparam int PIPE_LAT_DEF  = 4;
  localparam int DRAIN_MAX_DEF = 64;
  localparam int MIN_DIM       = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    FILL  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } ctrl_state_e;

  // Callers zero-extend their cfg fields to 32 bits.
  function automatic logic dims_legal(input logic [31:0] w, input logic [31:0] h);
    return (w >= 32'(MIN_DIM)) && (h >= 32'(MIN_DIM));
  endfunction

endpackage

// File: rtl/frame_out_framer.sv
// -----------------------------------------------------------------------------
// frame_out_framer
// Re-frames a filter's qualified output stream into sof/eol/eof-marked beats.
// Tracks column, row and total output count; beats beyond the frame total are
// dropped. Output is registered (one cycle after the filter beat).
// Ports:
//   clk, rst      clock, async active-high reset
//   clr_i         clear counters (frame start)
//   active_i      capture window open
//   width_i       pixels per line
//   total_i       pixels per frame
//   f_out_i       filter data_out
//   f_out_en_i    filter data_out_en
//   m_*_o         framed output beat
//   out_cnt_o     number of beats emitted so far this frame
// -----------------------------------------------------------------------------
module frame_out_framer
  import gauss_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int W_BITS = W_BITS_DEF,
  parameter int H_BITS = H_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     active_i,
  input  logic [W_BITS-1:0]        width_i,
  input  logic [W_BITS+H_BITS-1:0] total_i,
  input  logic [DATA_W-1:0]        f_out_i,
  input  logic                     f_out_en_i,
  output logic [DATA_W-1:0]        m_data_o,
  output logic                     m_valid_o,
  output logic                     m_sof_o,
  output logic                     m_eol_o,
  output logic                     m_eof_o,
  output logic [W_BITS+H_BITS-1:0] out_cnt_o
);

  localparam int CNT_W = W_BITS + H_BITS;
  localparam logic [W_BITS-1:0] W_ONE   = W_BITS'(1);
  localparam logic [H_BITS-1:0] H_ONE   = H_BITS'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [W_BITS-1:0] col_q, col_d;
  logic [H_BITS-1:0] row_q, row_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_sof_q, m_sof_d;
  logic              m_eol_q, m_eol_d;
  logic              m_eof_q, m_eof_d;
  logic              take;
  logic              last_col;

  assign take     = active_i & f_out_en_i & (out_cnt_q < total_i);
  assign last_col = (col_q == (width_i - W_ONE));

  always_comb begin
    out_cnt_d = out_cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    m_valid_d = take;
    m_sof_d   = take & (out_cnt_q == '0);
    m_eol_d   = take & last_col;
    m_eof_d   = take & (out_cnt_q == (total_i - CNT_ONE));
    m_data_d  = take ? f_out_i : m_data_q;

    if (clr_i) begin
      out_cnt_d = '0;
      col_d     = '0;
      row_d     = '0;
    end else if (take) begin
      out_cnt_d = out_cnt_q + CNT_ONE;
      if (last_col) begin
        col_d = '0;
        row_d = row_q + H_ONE;
      end else begin
        col_d = col_q + W_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
      m_eof_q   <= 1'b0;
    end else begin
      out_cnt_q <= out_cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_sof_q   <= m_sof_d;
      m_eol_q   <= m_eol_d;
      m_eof_q   <= m_eof_d;
    end
  end

  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_sof_o   = m_sof_q;
  assign m_eol_o   = m_eol_q;
  assign m_eof_o   = m_eof_q;
  assign out_cnt_o = out_cnt_q;

endmodule

// File: rtl/gauss_frame_ctrl.sv
// -----------------------------------------------------------------------------
// gauss_frame_ctrl
// Frame sequencer between a pixel source and a 3x3 line-buffer window filter.
// Latches the frame size on start, gates source beats into the filter enable,
// injects flush enables so the last rows leave the filter, and re-frames the
// filter output with sof/eol/eof plus a done pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; cfg checked and latched on a legal start
// SYNC  | discarding source beats until the s_sof beat (pixel 1)
// FILL  | forwarding source pixels 2..N to the filter
// FLUSH | W+PIPE_LAT enables with zero data to push the last rows out
// DRAIN | waiting for the last output beat, bounded by DRAIN_MAX cycles
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, cfg_width/height  frame request and size
//   busy, done, err          status (done/err are one-cycle pulses)
//   s_data/valid/sof/ready   source stream
//   f_data, f_en             to filter data_in / data_in_en
//   f_out, f_out_en          from filter data_out / data_out_en
//   m_data/valid/sof/eol/eof framed output stream
// -----------------------------------------------------------------------------
module gauss_frame_ctrl
  import gauss_ctrl_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int W_BITS    = W_BITS_DEF,
  parameter int H_BITS    = H_BITS_DEF,
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_BITS-1:0] cfg_width,
  input  logic [H_BITS-1:0] cfg_height,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_sof,
  output logic              s_ready,
  output logic [DATA_W-1:0] f_data,
  output logic              f_en,
  input  logic [DATA_W-1:0] f_out,
  input  logic              f_out_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int CNT_W = W_BITS + H_BITS;
  localparam int FL_W  = W_BITS + 1;
  localparam int DR_W  = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [FL_W-1:0]  FL_ONE  = FL_W'(1);
  localparam logic [DR_W-1:0]  DR_ONE  = DR_W'(1);

  ctrl_state_e       state_q, state_d;
  logic [W_BITS-1:0] w_q, w_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [DR_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              frame_clr;
  logic              frame_active;
  logic [CNT_W-1:0]  out_cnt;

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    n_d         = n_q;
    in_cnt_d    = in_cnt_q;
    flush_cnt_d = flush_cnt_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    frame_clr   = 1'b0;
    s_ready     = 1'b0;
    f_en        = 1'b0;
    f_data      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (dims_legal(32'(cfg_width), 32'(cfg_height))) begin
            w_d       = cfg_width;
            n_d       = {{H_BITS{1'b0}}, cfg_width} * {{W_BITS{1'b0}}, cfg_height};
            in_cnt_d  = '0;
            frame_clr = 1'b1;
            state_d   = SYNC;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SYNC: begin
        s_ready = 1'b1;
        if (s_valid && s_sof) begin
          f_en     = 1'b1;
          f_data   = s_data;
          in_cnt_d = CNT_ONE;
          state_d  = FILL;
        end
      end

      FILL: begin
        s_ready = (in_cnt_q < n_q);
        f_en    = s_valid & s_ready;
        f_data  = s_data;
        if (f_en) begin
          in_cnt_d = in_cnt_q + CNT_ONE;
          // A second sof inside the frame is flagged but the pixel still counts.
          if (s_sof) begin
            err_d = 1'b1;
          end
          if (in_cnt_q == (n_q - CNT_ONE)) begin
            flush_cnt_d = FL_W'(w_q) + FL_W'(PIPE_LAT);
            state_d     = FLUSH;
          end
        end
      end

      FLUSH: begin
        f_en        = 1'b1;
        flush_cnt_d = flush_cnt_q - FL_ONE;
        if (flush_cnt_q == FL_ONE) begin
          if (out_cnt == n_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            drain_cnt_d = DR_W'(DRAIN_MAX);
            state_d     = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (out_cnt == n_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (drain_cnt_q == DR_ONE) begin
          // Filter never delivered the full frame: end it with an error.
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - DR_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      w_q         <= '0;
      n_q         <= '0;
      in_cnt_q    <= '0;
      flush_cnt_q <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      n_q         <= n_d;
      in_cnt_q    <= in_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign frame_active = (state_q == FILL) || (state_q == FLUSH) || (state_q == DRAIN);

  frame_out_framer #(
    .DATA_W (DATA_W),
    .W_BITS (W_BITS),
    .H_BITS (H_BITS)
  ) u_framer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (frame_clr),
    .active_i   (frame_active),
    .width_i    (w_q),
    .total_i    (n_q),
    .f_out_i    (f_out),
    .f_out_en_i (f_out_en),
    .m_data_o   (m_data),
    .m_valid_o  (m_valid),
    .m_sof_o    (m_sof),
    .m_eol_o    (m_eol),
    .m_eof_o    (m_eof),
    .out_cnt_o  (out_cnt)
  );

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_gauss_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gauss_frame_ctrl
// Directed + randomized bench for gauss_frame_ctrl. The filter is replaced by
// a stub that echoes f_en/f_data as f_out_en/f_out after W+PIPE_LAT cycles,
// optionally passing only a limited number of beats.
// -----------------------------------------------------------------------------
module tb_gauss_frame_ctrl;

  localparam int DATA_W    = 8;
  localparam int W_BITS    = 11;
  localparam int H_BITS    = 11;
  localparam int PIPE_LAT  = 4;
  localparam int DRAIN_MAX = 64;

  logic              clk;
  logic              rst;
  logic              start;
  logic [W_BITS-1:0] cfg_width;
  logic [H_BITS-1:0] cfg_height;
  logic              busy, done, err;
  logic [DATA_W-1:0] s_data;
  logic              s_valid, s_sof, s_ready;
  logic [DATA_W-1:0] f_data;
  logic              f_en;
  logic [DATA_W-1:0] f_out;
  logic              f_out_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid, m_sof, m_eol, m_eof;

  int checks   = 0;
  int failures = 0;

  gauss_frame_ctrl #(
    .DATA_W(DATA_W), .W_BITS(W_BITS), .H_BITS(H_BITS),
    .PIPE_LAT(PIPE_LAT), .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .busy(busy), .done(done), .err(err),
    .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
    .f_data(f_data), .f_en(f_en), .f_out(f_out), .f_out_en(f_out_en),
    .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- filter stub: pure delay line with a beat limit ----------
  logic [DATA_W-1:0] sd [32];
  logic              se [32];
  int stub_lat   = 8;
  int echo_limit = 1000000;
  int echo_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        sd[i] <= '0;
        se[i] <= 1'b0;
      end
      echo_cnt <= 0;
    end else begin
      sd[0] <= f_data;
      se[0] <= f_en;
      for (int i = 1; i < 32; i++) begin
        sd[i] <= sd[i-1];
        se[i] <= se[i-1];
      end
      if (f_out_en) echo_cnt <= echo_cnt + 1;
    end
  end

  assign f_out_en = se[stub_lat-1] && (echo_cnt < echo_limit);
  assign f_out    = sd[stub_lat-1];

  // ---------------- passive monitor: records events only -------------------
  typedef struct {
    logic [DATA_W-1:0] d;
    logic sof, eol, eof;
    int   cyc;
  } beat_t;
  typedef struct {
    int   cyc;
    logic busy;
    logic err;
  } done_t;

  beat_t beats[$];
  done_t dones[$];
  beat_t mb;
  done_t md;
  int err_cnt = 0;
  int fen_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid) begin
        mb.d = m_data; mb.sof = m_sof; mb.eol = m_eol; mb.eof = m_eof; mb.cyc = cyc;
        beats.push_back(mb);
      end
      if (done) begin
        md.cyc = cyc; md.busy = busy; md.err = err;
        dones.push_back(md);
      end
      if (err) err_cnt++;
      if (f_en) fen_cnt++;
    end
  end

  // ---------------- checking helper ----------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {48'd0, busy, done, err, s_ready, f_en, m_valid, m_sof, m_eol, m_eof,
            (f_data != 0), (m_data != 0), 5'd0};
  endfunction

  // Runs one legal frame. Expected output: pixels in order, sof on beat 0,
  // eol every W beats, eof on beat N-1, done one cycle after eof.
  // bad >= 0 puts an extra sof on that pixel index; lim caps stub echoes.
  task automatic run_frame(input int w, input int h, input int junk, input int bad,
                           input int vprob, input int lim, input bit timeout);
    int n;
    int b0, d0, e0, f0, i, j, ncnt, waited;
    logic [DATA_W-1:0] pix[$];
    n = w * h;
    for (int k = 0; k < n; k++) pix.push_back(DATA_W'($urandom_range(1, 255)));
    b0 = beats.size(); d0 = dones.size(); e0 = err_cnt; f0 = fen_cnt;
    stub_lat   = w + PIPE_LAT;
    echo_limit = echo_cnt + lim;

    @(posedge clk); #1;
    cfg_width = W_BITS'(w); cfg_height = H_BITS'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    i = 0; j = 0;
    while (i < n) begin
      if (j < junk) begin
        s_valid = 1'b1; s_sof = 1'b0; s_data = DATA_W'($urandom);
      end else if (int'($urandom_range(99)) < vprob) begin
        s_valid = 1'b1; s_sof = (i == 0) || (i == bad); s_data = pix[i];
      end else begin
        s_valid = 1'b0; s_sof = 1'($urandom_range(1)); s_data = DATA_W'($urandom);
      end
      @(negedge clk);
      chk("s_ready_frame", s_ready, 1);
      if (j < junk) begin
        chk("junk_f_en", f_en, 0);
        j++;
      end else if (s_valid) begin
        chk("pix_f_en", f_en, 1);
        chk("pix_f_data", f_data, pix[i]);
        i++;
      end else begin
        chk("gap_f_en", f_en, 0);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_sof = 1'b0;
    @(negedge clk);
    chk("s_ready_after_last", s_ready, 0);
    chk("flush_f_en", f_en, 1);
    chk("flush_f_data", f_data, 0);

    waited = 0;
    while (dones.size() == d0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("done_seen", dones.size() > d0, 1);
    if (dones.size() > d0) begin
      chk("done_busy_low", dones[d0].busy, 0);
      chk("done_err", dones[d0].err, timeout);
      if (beats.size() > b0) begin
        if (timeout)
          chk("drain_wait", (dones[d0].cyc - beats[beats.size()-1].cyc) >= DRAIN_MAX, 1);
        else
          chk("done_after_eof", dones[d0].cyc, beats[beats.size()-1].cyc + 1);
      end
    end

    // Let the stub's flush echoes pass; none of them may be framed.
    repeat (w + PIPE_LAT + 4) @(negedge clk);
    ncnt = beats.size() - b0;
    chk("beat_count", ncnt, timeout ? n - 2 : n);
    for (int k = 0; k < ncnt && k < n; k++) begin
      chk("m_data", beats[b0+k].d, pix[k]);
      chk("m_sof", beats[b0+k].sof, k == 0);
      chk("m_eol", beats[b0+k].eol, (k % w) == w - 1);
      chk("m_eof", beats[b0+k].eof, k == n - 1);
    end
    chk("f_en_total", fen_cnt - f0, n + w + PIPE_LAT);
    chk("err_count", err_cnt - e0, ((bad > 0) ? 1 : 0) + (timeout ? 1 : 0));
    chk("single_done", dones.size() - d0, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic illegal_start(input int w, input int h);
    int f0, e0;
    f0 = fen_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    cfg_width = W_BITS'(w); cfg_height = H_BITS'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("illegal_err_pulse", err, 1);
    chk("illegal_busy", busy, 0);
    @(negedge clk);
    chk("illegal_err_one_cycle", err, 0);
    repeat (10) @(negedge clk);
    chk("illegal_no_f_en", fen_cnt - f0, 0);
    chk("illegal_busy_after", busy, 0);
    chk("illegal_err_count", err_cnt - e0, 1);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
    s_data = '0; s_valid = 1'b0; s_sof = 1'b0;
    #2;
    chk("reset_outputs", all_outs(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", all_outs(), 0);

    // Back-to-back 4x3 frame.
    run_frame(4, 3, 0, -1, 100, 1000000, 1'b0);
    // Same size, source valid toggling about half the time.
    run_frame(4, 3, 0, -1, 50, 1000000, 1'b0);
    // Junk beats ahead of sof.
    run_frame(4, 3, 3, -1, 100, 1000000, 1'b0);
    // Extra sof on pixel 5.
    run_frame(4, 3, 0, 4, 100, 1000000, 1'b0);
    // Illegal sizes.
    illegal_start(2, 3);
    illegal_start(5, 2);
    // Filter withholds the last two output beats -> drain timeout.
    run_frame(4, 3, 0, -1, 100, 10, 1'b1);

    // Reset in the middle of FILL.
    d0 = dones.size();
    stub_lat = 4 + PIPE_LAT;
    @(posedge clk); #1;
    cfg_width = 11'd4; cfg_height = 11'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_sof = (k == 0); s_data = DATA_W'(k + 1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("midframe_reset_outputs", all_outs(), 0);
    s_valid = 1'b0; s_sof = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_done_on_reset", dones.size() - d0, 0);
    chk("idle_after_reset", busy, 0);
    run_frame(4, 3, 0, -1, 100, 1000000, 1'b0);

    // Randomized frames.
    for (int r = 0; r < 4; r++) begin
      run_frame(int'($urandom_range(3, 6)), int'($urandom_range(3, 5)),
                int'($urandom_range(0, 3)), -1, int'($urandom_range(40, 100)),
                1000000, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
